// File: rtl/contador_desc.sv
// Modulo-MODULO down counter with async reset, sync preset and clamped parallel load.
// Stages cascade by feeding bo into the next stage's en to build multi-digit countdowns.
module contador_desc #(
  parameter int WIDTH  = 4,
  parameter int MODULO = 10
) (
  input  logic             clk,
  input  logic             r,
  input  logic             s,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  output logic [WIDTH-1:0] q,
  output logic             zero,
  output logic             bo
);

  localparam logic [WIDTH-1:0] LP_MAX = WIDTH'(MODULO - 1);
  // One extra bit so MODULO == 2^WIDTH is representable in the load compare
  localparam logic [WIDTH:0]   LP_MOD = (WIDTH + 1)'(MODULO);

  logic [WIDTH-1:0] r_q;
  logic             w_qZero;
  logic [WIDTH-1:0] w_ldVal;
  logic [WIDTH-1:0] w_decVal;

  assign w_qZero  = (r_q == '0);
  assign w_ldVal  = ({1'b0, d} < LP_MOD) ? d : LP_MAX;
  // Wrap is an explicit compare, so a non-power-of-two modulus never reaches 2^WIDTH-1
  assign w_decVal = w_qZero ? LP_MAX : (r_q - 1'b1);

  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      r_q <= '0;
    end else if (s) begin
      r_q <= LP_MAX;
    end else if (ld) begin
      r_q <= w_ldVal;
    end else if (en) begin
      r_q <= w_decVal;
    end
  end

  assign q    = r_q;
  assign zero = w_qZero;
  // Borrow ignores s/ld on purpose: the downstream stage still steps when they coincide
  assign bo   = en & w_qZero;

endmodule

// File: tb/tb_contador_desc.sv
// Directed bench for contador_desc: MODULO 10, MODULO 6 and a two-stage 99..00 cascade.
module tb_contador_desc;

  logic       clk = 1'b0;
  logic       r;

  logic       s, ld, en;
  logic [3:0] d;
  logic [3:0] q;
  logic       zero, bo;

  logic       m6S, m6Ld, m6En;
  logic [3:0] m6D;
  logic [3:0] m6Q;
  logic       m6Zero, m6Bo;

  logic       cS, cEn;
  logic [3:0] lsQ, msQ;
  logic       lsZero, lsBo, msZero, msBo;

  int compareCount = 0;
  int errorCount   = 0;
  int expQ;
  int expV;

  always #5 clk = ~clk;

  contador_desc #(.WIDTH(4), .MODULO(10)) u_dut (
    .clk(clk), .r(r), .s(s), .ld(ld), .d(d), .en(en),
    .q(q), .zero(zero), .bo(bo)
  );

  contador_desc #(.WIDTH(4), .MODULO(6)) u_m6 (
    .clk(clk), .r(r), .s(m6S), .ld(m6Ld), .d(m6D), .en(m6En),
    .q(m6Q), .zero(m6Zero), .bo(m6Bo)
  );

  contador_desc #(.WIDTH(4), .MODULO(10)) u_ls (
    .clk(clk), .r(r), .s(cS), .ld(1'b0), .d(4'd0), .en(cEn),
    .q(lsQ), .zero(lsZero), .bo(lsBo)
  );

  contador_desc #(.WIDTH(4), .MODULO(10)) u_ms (
    .clk(clk), .r(r), .s(cS), .ld(1'b0), .d(4'd0), .en(lsBo),
    .q(msQ), .zero(msZero), .bo(msBo)
  );

  // Compare one observed value against its hand-computed expectation
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compareCount++;
    assert (obs === exp) else begin
      errorCount++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it, away from the edge
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  initial begin
    r = 1'b1; s = 1'b0; ld = 1'b0; en = 1'b0; d = 4'd0;
    m6S = 1'b0; m6Ld = 1'b0; m6En = 1'b0; m6D = 4'd0;
    cS = 1'b0; cEn = 1'b0;
    #3;
    checkOutput("reset_q", q, 0);
    checkOutput("reset_zero", zero, 1);
    checkOutput("reset_bo_en0", bo, 0);
    en = 1'b1; #1;
    checkOutput("reset_bo_en1", bo, 1);
    en = 1'b0;
    applyStimulus();
    r = 1'b0;

    ld = 1'b1; d = 4'd7;
    applyStimulus();
    ld = 1'b0;
    checkOutput("load7_q", q, 7);
    checkOutput("load7_zero", zero, 0);
    #2 r = 1'b1;
    #1;
    checkOutput("async_reset_q", q, 0);
    checkOutput("async_reset_zero", zero, 1);
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkOutput("reset_hold_q", q, 0);
    end
    r = 1'b0; en = 1'b0;

    s = 1'b1;
    applyStimulus();
    s = 1'b0;
    checkOutput("preset_q", q, 9);
    en = 1'b1;
    expQ = 9;
    for (int i = 0; i < 11; i++) begin
      checkOutput("count_bo", bo, (expQ == 0) ? 1 : 0);
      checkOutput("count_zero", zero, (expQ == 0) ? 1 : 0);
      applyStimulus();
      expQ = (expQ == 0) ? 9 : expQ - 1;
      checkOutput("count_q", q, expQ);
    end
    en = 1'b0;

    ld = 1'b1; d = 4'd5;
    applyStimulus();
    checkOutput("load5_q", q, 5);
    d = 4'd13;
    applyStimulus();
    checkOutput("clamp13_q", q, 9);
    d = 4'd10;
    applyStimulus();
    checkOutput("clamp10_q", q, 9);
    d = 4'd3; en = 1'b1;
    applyStimulus();
    checkOutput("load_no_dec_q", q, 3);

    s = 1'b1; d = 4'd2;
    applyStimulus();
    checkOutput("prio_preset_q", q, 9);
    s = 1'b0; en = 1'b0; d = 4'd4;
    applyStimulus();
    ld = 1'b0;
    checkOutput("load4_q", q, 4);
    for (int i = 0; i < 4; i++) begin
      applyStimulus();
      checkOutput("hold_q", q, 4);
    end

    ld = 1'b1; d = 4'd0;
    applyStimulus();
    checkOutput("load0_q", q, 0);
    d = 4'd6; en = 1'b1;
    #1;
    checkOutput("bo_during_load", bo, 1);
    applyStimulus();
    checkOutput("load6_q", q, 6);
    ld = 1'b0; en = 1'b0;

    m6Ld = 1'b1; m6D = 4'd0;
    applyStimulus();
    m6Ld = 1'b0;
    checkOutput("m6_load0_q", m6Q, 0);
    checkOutput("m6_zero", m6Zero, 1);
    m6En = 1'b1;
    #1;
    checkOutput("m6_bo", m6Bo, 1);
    applyStimulus();
    checkOutput("m6_wrap_q", m6Q, 5);
    applyStimulus();
    checkOutput("m6_dec_q", m6Q, 4);
    m6En = 1'b0; m6Ld = 1'b1; m6D = 4'd6;
    applyStimulus();
    checkOutput("m6_clamp6_q", m6Q, 5);
    m6D = 4'd5;
    applyStimulus();
    checkOutput("m6_load5_q", m6Q, 5);
    m6Ld = 1'b0;

    cS = 1'b1;
    applyStimulus();
    cS = 1'b0;
    checkOutput("casc_preset", msQ * 10 + lsQ, 99);
    cEn = 1'b1;
    expV = 99;
    for (int i = 0; i < 100; i++) begin
      applyStimulus();
      expV = (expV == 0) ? 99 : expV - 1;
      checkOutput("casc_value", msQ * 10 + lsQ, expV);
    end
    checkOutput("casc_final_ms", msQ, 9);
    checkOutput("casc_final_ls", lsQ, 9);
    cEn = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, errorCount);
    $finish;
  end

endmodule
